// File: rtl/utxd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : utxd_fifo
// Description : 8N1 UART transmitter fed by a DEPTH-entry byte FIFO; frames
//               are sent back-to-back while data is waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module utxd_fifo #(
    parameter int F_CLK = 50_000_000,
    parameter int BAUD  = 115200,
    parameter int DEPTH = 4
) (
    input  logic       tx_clk,
    input  logic       rst,
    input  logic       st,
    input  logic [7:0] tx_dat,
    output logic       TXD,
    output logic       en_tx_byte,
    output logic [3:0] cb_bit_tx,
    output logic       ce_tact,
    output logic       ok_tx_byte,
    output logic       full,
    output logic       empty,
    output logic       ovf
);

    localparam int c_NT = F_CLK / BAUD;
    localparam int c_TW = (c_NT > 1) ? $clog2(c_NT) : 1;
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_TW-1:0] c_TACT_LAST = c_TW'(c_NT - 1);
    localparam logic [c_CW-1:0] c_CNT_MAX   = c_CW'(DEPTH);
    localparam logic [3:0]      c_BIT_LAST_DATA = 4'd8;
    localparam logic [3:0]      c_BIT_STOP  = 4'd9;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_mem [DEPTH];
    logic [c_PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0] r_count, w_count_nxt;
    logic [c_TW-1:0] r_tact, w_tact_nxt;
    logic [3:0]      r_bit, w_bit_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            r_txd, w_txd_nxt;
    logic            r_full, r_empty, r_ovf;
    logic            w_ce, w_frame_end, w_pop, w_wr;

    assign w_ce        = (r_state == S_SEND) && (r_tact == c_TACT_LAST);
    assign w_frame_end = w_ce && (r_bit == c_BIT_STOP);
    // A pop happens whenever the line is free to start a new frame.
    assign w_pop       = !r_empty && ((r_state == S_IDLE) || w_frame_end);
    assign w_wr        = st && ((r_count != c_CNT_MAX) || w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_tact_nxt  = r_tact;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = S_SEND;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_txd_nxt   = 1'b0;
                    w_bit_nxt   = 4'd0;
                    w_tact_nxt  = '0;
                end
            end
            S_SEND: begin
                if (w_ce) begin
                    w_tact_nxt = '0;
                    if (r_bit == c_BIT_STOP) begin
                        if (w_pop) begin
                            w_shift_nxt = r_mem[r_rd_ptr];
                            w_txd_nxt   = 1'b0;
                            w_bit_nxt   = 4'd0;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_txd_nxt   = 1'b1;
                            w_bit_nxt   = 4'd0;
                        end
                    end else begin
                        w_bit_nxt = r_bit + 4'd1;
                        if (r_bit < c_BIT_LAST_DATA) begin
                            w_txd_nxt   = r_shift[0];
                            w_shift_nxt = {1'b0, r_shift[7:1]};
                        end else begin
                            w_txd_nxt = 1'b1;
                        end
                    end
                end else begin
                    w_tact_nxt = r_tact + c_TW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + c_CW'(1);
            2'b01:   w_count_nxt = r_count - c_CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_tact   <= '0;
            r_bit    <= 4'd0;
            r_shift  <= 8'd0;
            r_txd    <= 1'b1;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tact  <= w_tact_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_CNT_MAX);
            r_empty <= (w_count_nxt == '0);
            r_ovf   <= st && !w_wr;
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge tx_clk) begin
        if (!rst && w_wr)
            r_mem[r_wr_ptr] <= tx_dat;
    end

    assign TXD        = r_txd;
    assign en_tx_byte = (r_state == S_SEND);
    assign cb_bit_tx  = r_bit;
    assign ce_tact    = w_ce;
    assign ok_tx_byte = w_frame_end;
    assign full       = r_full;
    assign empty      = r_empty;
    assign ovf        = r_ovf;

endmodule
`default_nettype wire
